// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MIDSAMPLE  = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_e;

  // True when a 4-bit tick counter has reached the given terminal value.
  function automatic logic tick_at(input logic [3:0] count, input int unsigned target);
    return count == 4'(target);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte interface from uart_rx to its consumer.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int DBIT = 8
);

  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;
`endif

  modport master (
    output dout,
    output rx_done_tick,
    output frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output parity_err
`endif
  );

  modport slave (
    input dout,
    input rx_done_tick,
    input frame_err
`ifdef UART_RX_PARITY_EN
    ,
    input parity_err
`endif
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both stages
// reset to RESET_VAL so an idle-high line does not glitch low out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments make each stage take the other's pre-edge
  // value; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, centre-sampled start/data/stop recovery.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      s_tick,
  input  logic      rx,
  uart_rx_if.master rx_bus
);

  localparam logic [2:0] BIT_LAST = 3'(DBIT - 1);

  logic            rx_s;
  uart_state_e     state_q, state_d;
  logic            rx_prev_q, rx_prev_d;
  logic [3:0]      count_q, count_d;
  logic [2:0]      bit_count_q, bit_count_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_done_tick_q, rx_done_tick_d;
`ifdef UART_RX_PARITY_EN
  logic            par_bit_q, par_bit_d;
  logic            parity_err_q, parity_err_d;
`endif

  logic start_edge;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // A start is a high-to-low transition seen across two consecutive ticks,
  // so a line stuck low cannot re-arm the receiver.
  assign start_edge = !rx_s && rx_prev_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves a _d
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    if (s_tick) begin
      unique case (state_q)
        IDLE:  if (start_edge) state_d = START;
        START: if (tick_at(count_q, MIDSAMPLE)) state_d = rx_s ? IDLE : DATA;
        DATA: begin
          if (tick_at(count_q, OVERSAMPLE - 1) && bit_count_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick_at(count_q, OVERSAMPLE - 1)) state_d = STOP;
`endif
        STOP:  if (tick_at(count_q, SB_TICK - 1)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs
  always_comb begin
    rx_prev_d      = s_tick ? rx_s : rx_prev_q;
    count_d        = count_q;
    bit_count_d    = bit_count_q;
    shift_d        = shift_q;
    dout_d         = dout_q;
    frame_err_d    = frame_err_q;
    rx_done_tick_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d      = par_bit_q;
    parity_err_d   = parity_err_q;
`endif
    if (s_tick) begin
      unique case (state_q)
        IDLE: if (start_edge) count_d = '0;
        START: begin
          if (tick_at(count_q, MIDSAMPLE)) begin
            if (!rx_s) begin
              count_d     = '0;
              bit_count_d = '0;
            end
          end else begin
            count_d = count_q + 4'd1;
          end
        end
        DATA: begin
          if (tick_at(count_q, OVERSAMPLE - 1)) begin
            shift_d = {rx_s, shift_q[DBIT-1:1]};
            count_d = '0;
            if (bit_count_q != BIT_LAST) bit_count_d = bit_count_q + 3'd1;
          end else begin
            count_d = count_q + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_at(count_q, OVERSAMPLE - 1)) begin
            par_bit_d = rx_s;
            count_d   = '0;
          end else begin
            count_d = count_q + 4'd1;
          end
        end
`endif
        STOP: begin
          if (tick_at(count_q, SB_TICK - 1)) begin
            dout_d         = shift_q;
            frame_err_d    = ~rx_s;
            rx_done_tick_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d   = ^{shift_q, par_bit_q};
`endif
          end else begin
            count_d = count_q + 4'd1;
          end
        end
        default: count_d = '0;
      endcase
    end
  end

  // NOTE: the shift register is reset like every other flop here; it is a
  // handful of bits, and the reset keeps X out of dout after power-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev_q      <= 1'b1;
      count_q        <= '0;
      bit_count_q    <= '0;
      shift_q        <= '0;
      dout_q         <= '0;
      frame_err_q    <= 1'b0;
      rx_done_tick_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q      <= 1'b0;
      parity_err_q   <= 1'b0;
`endif
    end else begin
      rx_prev_q      <= rx_prev_d;
      count_q        <= count_d;
      bit_count_q    <= bit_count_d;
      shift_q        <= shift_d;
      dout_q         <= dout_d;
      frame_err_q    <= frame_err_d;
      rx_done_tick_q <= rx_done_tick_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q      <= par_bit_d;
      parity_err_q   <= parity_err_d;
`endif
    end
  end

  // Output logic
  always_comb begin
    rx_bus.dout         = dout_q;
    rx_bus.rx_done_tick = rx_done_tick_q;
    rx_bus.frame_err    = frame_err_q;
`ifdef UART_RX_PARITY_EN
    rx_bus.parity_err   = parity_err_q;
`endif
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: clean, false-start, framing-error,
// back-to-back, reset-abort, break and (with UART_RX_PARITY_EN) parity frames.
module tb_uart_rx;

  localparam int CLK_DIV = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned FRAME_LAT = 153 + 16;
`else
  localparam int unsigned FRAME_LAT = 153;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        fe;
    logic        pe;
    int unsigned tick;
  } rec_t;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        s_tick = 1'b0;
  logic        rx     = 1'b1;
  int unsigned tick_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  rec_t        done_q[$];
  int unsigned t0, t1;

  uart_rx_if #(.DBIT(8)) rx_bus ();

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick),
    .rx     (rx),
    .rx_bus (rx_bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (CLK_DIV - 1) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(posedge clk) if (s_tick) tick_cnt <= tick_cnt + 1;

  // Record every done pulse with the tick count at which it appeared.
  always @(negedge clk) begin
    if (rx_bus.rx_done_tick) begin
`ifdef UART_RX_PARITY_EN
      done_q.push_back('{data: rx_bus.dout, fe: rx_bus.frame_err, pe: rx_bus.parity_err, tick: tick_cnt});
`else
      done_q.push_back('{data: rx_bus.dout, fe: rx_bus.frame_err, pe: 1'b0, tick: tick_cnt});
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Returns 1 ns after the n-th following tick edge.
  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk iff s_tick);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_bit, output int unsigned start_tick);
    start_tick = tick_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`endif
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] data, input logic fe,
                           input logic pe, input int unsigned start_tick);
    rec_t r;
    check({tag, " present"}, 32'(done_q.size() != 0), 32'd1);
    if (done_q.size() != 0) begin
      r = done_q.pop_front();
      check({tag, " dout"}, 32'(r.data), 32'(data));
      check({tag, " frame_err"}, 32'(r.fe), 32'(fe));
`ifdef UART_RX_PARITY_EN
      check({tag, " parity_err"}, 32'(r.pe), 32'(pe));
`endif
      check({tag, " latency"}, r.tick - start_tick, FRAME_LAT);
    end
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    check("reset dout", 32'(rx_bus.dout), 32'h00);
    check("reset done", 32'(rx_bus.rx_done_tick), 32'd0);
    check("reset frame_err", 32'(rx_bus.frame_err), 32'd0);
`ifdef UART_RX_PARITY_EN
    check("reset parity_err", 32'(rx_bus.parity_err), 32'd0);
`endif
    reset = 1'b1;
    wait_ticks(4);

    // Clean byte (0x55 has even weight: parity bit 0)
    send_frame(8'h55, 1'b1, 1'b0, t0);
    wait_ticks(4);
    pop_check("clean", 8'h55, 1'b0, 1'b0, t0);
    check("clean single pulse", done_q.size(), 32'd0);

    // False start: four low ticks, then back high
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    check("false_start no pulse", done_q.size(), 32'd0);
    check("false_start dout held", 32'(rx_bus.dout), 32'h55);

    // Framing error: stop bit low
    send_frame(8'hA3, 1'b0, 1'b0, t0);
    wait_ticks(8);
    pop_check("framing", 8'hA3, 1'b1, 1'b0, t0);
    check("framing single pulse", done_q.size(), 32'd0);

    // Back-to-back with no idle gap
    send_frame(8'hA3, 1'b1, 1'b0, t0);
    send_frame(8'h0F, 1'b1, 1'b0, t1);
    wait_ticks(8);
    pop_check("b2b first", 8'hA3, 1'b0, 1'b0, t0);
    pop_check("b2b second", 8'h0F, 1'b0, 1'b0, t1);
    check("b2b pulse count", done_q.size(), 32'd0);

    // Reset in the middle of data bit 4 aborts the frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b0;
    wait_ticks(8);
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("abort dout cleared", 32'(rx_bus.dout), 32'h00);
    reset = 1'b1;
    wait_ticks(30);
    check("abort no pulse", done_q.size(), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, t0);
    wait_ticks(8);
    pop_check("after abort", 8'h3C, 1'b0, 1'b0, t0);
    check("after abort single", done_q.size(), 32'd0);

    // Break: line held low far longer than a frame
    t0 = tick_cnt;
    rx = 1'b0;
    wait_ticks(400);
    pop_check("break", 8'h00, 1'b1, 1'b0, t0);
    check("break no re-arm", done_q.size(), 32'd0);
    rx = 1'b1;
    wait_ticks(20);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: parity bit 1 is correct, 0 is an error
    send_frame(8'h07, 1'b1, 1'b1, t0);
    wait_ticks(8);
    pop_check("parity good", 8'h07, 1'b0, 1'b0, t0);
    send_frame(8'h07, 1'b1, 1'b0, t0);
    wait_ticks(8);
    pop_check("parity bad", 8'h07, 1'b0, 1'b1, t0);
    check("parity pulse count", done_q.size(), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
